dac_serial_tx: RTL and testbench
================================

// Module: dac_serial_tx
// PURPOSE
//   Downstream stage of the DDS sine path. Takes 8-bit waveform samples through a valid/ready handshake
//   and buffers one sample. At a fixed sample-rate tick it sends that sample as one serial frame
//   (CS_N/SCLK/DIN, MSB first) to an external serial DAC. One frame carries exactly one sample.
// PARAMETERS
//   DATA_W       8    sample width
//   FRAME_W      16   bits per DAC frame
//   LEAD_W       4    zero bits sent before the data; tail zeros = FRAME_W-LEAD_W-DATA_W (>=0)
//   SCLK_DIV     2    clk cycles per SCLK half-period (>=1)
//   FRAME_PERIOD 80   clk cycles between sample ticks; must be >= SCLK_DIV*(2*FRAME_W+1)+2
// PORTS
//   clk          in   1       system clock
//   rst          in   1       asynchronous reset, active high
//   en           in   1       1 = tick timer runs; 0 = no new frames start
//   in_data      in   DATA_W  sample from the DDS output
//   in_valid     in   1       in_data is valid
//   in_ready     out  1       = ~hold_full; transfer occurs when in_valid & in_ready
//   dac_cs_n     out  1       DAC chip select, active low
//   dac_sclk     out  1       DAC serial clock; idles low; DAC samples DIN on the rising edge
//   dac_din      out  1       DAC serial data
//   busy         out  1       high while a frame is in progress (state != IDLE)
//   frame_done   out  1       1-cycle pulse on the cycle dac_cs_n returns high
// BEHAVIOUR
//   Reset values: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, frame_done=0, hold_full=0 (so in_ready=1),
//     timer=0, state=IDLE, last sample=0. Reset mid-frame aborts the frame immediately (CS_N high async).
//   Hold register: loads in_data on a handshake and sets hold_full. It is cleared when a frame starts.
//     in_ready is ~hold_full (registered), so a load and a frame start never fall in the same cycle.
//   Timer: while en=1, counts 0..FRAME_PERIOD-1 and wraps; tick=1 on the cycle the count is FRAME_PERIOD-1.
//     While en=0, the timer holds at 0 and there is no tick. Any frame in progress still completes.
//   FSM IDLE->SETUP->SHIFT->IDLE:
//     IDLE : on tick with hold_full -> latch shift reg = {LEAD_W'0, data, tail'0}, clear hold_full,
//            go to SETUP. On the next cycle dac_cs_n=0 and dac_din=shift[FRAME_W-1].
//     SETUP: CS_N low, SCLK low for SCLK_DIV cycles, then SCLK rises -> SHIFT.
//     SHIFT: each bit = SCLK high SCLK_DIV cycles, then low SCLK_DIV cycles.
//            dac_din advances on each falling edge except the last.
//            After the FRAME_W-th low phase: dac_cs_n=1, frame_done=1, state -> IDLE.
//     CS_N is low for exactly SCLK_DIV*(2*FRAME_W+1) cycles (66 at the defaults).
//   Tick in IDLE with hold_full=0: underrun (see CONFIGURATION).
//   A tick cannot arrive mid-frame, because of the FRAME_PERIOD constraint.
//   All outputs are registered; nothing combinational from the inputs reaches the DAC pins.
// CONFIGURATION
//   DAC_REPEAT_EN defined:
//     - an underrun tick resends the last transmitted sample (0 after reset);
//     - adds output port underrun (1 bit), a 1-cycle pulse on that tick.
//   DAC_REPEAT_EN undefined:
//     - an underrun tick is skipped: CS_N stays high and no frame is sent;
//     - there is no underrun port.
// STRUCTURE
//   Package dac_serial_pkg:
//     - state typedef (IDLE, SETUP, SHIFT);
//     - localparam function frame_cycles(FRAME_W, SCLK_DIV);
//     - parameter-legality checks.
//   Sub-module dac_rate_tick: FRAME_PERIOD counter with en and a tick output.
//   The FSM, hold register and shifter stay in dac_serial_tx.
// TESTING
//   1 Defaults, en=1, push 0xA5:
//       - the DAC model captures 0x0A50 MSB first on the SCLK rising edges;
//       - CS_N low 66 cycles, frame_done pulses once;
//       - in_ready returns high the cycle after the frame starts.
//   2 Stream 0x00,0xFF,0x80 with in_valid held high:
//       - in_ready deasserts while the buffer is full;
//       - frames start exactly 80 clk apart;
//       - captured words are 0x0000, 0x0FF0, 0x0800.
//   3 No sample at a tick:
//       - with DAC_REPEAT_EN, the previous word is resent and underrun pulses once;
//       - without it, CS_N stays high for that period.
//   4 Assert rst at cycle 30 of a frame:
//       - CS_N=1, SCLK=0, DIN=0 at once; in_ready=1;
//       - after release, the first frame waits for a full 80-cycle tick.
//   5 Drop en mid-frame:
//       - the frame completes with all 16 bits;
//       - no further frames while en=0, even with hold_full=1;
//       - re-enable: the buffered sample is sent 80 cycles later.

Source files
------------

// File: rtl/dac_serial_pkg.sv
// Shared types and elaboration helpers for the serial DAC transmitter.
// State encoding, frame length helper and parameter legality test.
package dac_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Number of clk cycles CS_N stays low for one frame.
    function automatic int frame_cycles(input int frame_w, input int sclk_div);
        return sclk_div * (2 * frame_w + 1);
    endfunction

    // A tick must never land inside a frame, and the frame must hold the sample.
    function automatic bit params_ok(
        input int data_w,
        input int frame_w,
        input int lead_w,
        input int sclk_div,
        input int frame_period
    );
        return (data_w >= 1)
            && (frame_w >= 2)
            && (lead_w >= 0)
            && (frame_w - lead_w - data_w >= 0)
            && (sclk_div >= 1)
            && (frame_period >= frame_cycles(frame_w, sclk_div) + 2);
    endfunction

endpackage

// File: rtl/dac_rate_tick.sv
// Sample-rate timer: counts 0..FRAME_PERIOD-1 while enabled.
// The tick marks the last count; disabling parks the count at 0.
module dac_rate_tick
    import dac_serial_pkg::*;
#(
    parameter int FRAME_PERIOD = 80
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_PERIOD - 1);

    logic [CW-1:0] count;

    // Free-running period counter, held at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/dac_serial_tx.sv
// Buffers one DDS sample and ships it to a serial DAC each sample tick.
// Optional DAC_REPEAT_EN resends the previous sample on an underrun.
module dac_serial_tx
    import dac_serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FRAME_W      = 16,
    parameter int LEAD_W       = 4,
    parameter int SCLK_DIV     = 2,
    parameter int FRAME_PERIOD = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_din,
    output logic              busy,
    output logic              frame_done
`ifdef DAC_REPEAT_EN
    ,
    output logic              underrun
`endif
);

    localparam int TAIL_W = FRAME_W - LEAD_W - DATA_W;
    localparam int CNT_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W  = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    if (!params_ok(DATA_W, FRAME_W, LEAD_W, SCLK_DIV, FRAME_PERIOD))
    begin : g_bad_params
        $error("dac_serial_tx: illegal parameter combination");
    end

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [BIT_W-1:0]   bcnt_q, bcnt_n;
    logic               low_q, low_n;
    logic [FRAME_W-1:0] shift_q, shift_n;
    logic               cs_n_q, cs_n_n;
    logic               sclk_q, sclk_n;
    logic               din_q, din_n;
    logic               done_q, done_n;
    logic               busy_q, busy_n;
    logic               hold_full_q, hold_full_n;
    logic [DATA_W-1:0]  hold_q, hold_n;
    logic [DATA_W-1:0]  src;
    logic [FRAME_W-1:0] word;
    logic               tick;
    logic               load;
    logic               start_ok;
`ifdef DAC_REPEAT_EN
    logic [DATA_W-1:0]  last_q, last_n;
    logic               ur_q, ur_n;
`endif

    dac_rate_tick #(
        .FRAME_PERIOD(FRAME_PERIOD)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    assign load = in_valid & ~hold_full_q;

    // Pick the sample for a new frame and place it between lead and tail zeros.
    always_comb begin
        src      = hold_q;
        start_ok = hold_full_q;
`ifdef DAC_REPEAT_EN
        start_ok = 1'b1;
        if (!hold_full_q) begin
            src = last_q;
        end
`endif
        word = FRAME_W'(src) << TAIL_W;
    end

    // Next-state and next-output logic for hold buffer and frame sequencer.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        bcnt_n      = bcnt_q;
        low_n       = low_q;
        shift_n     = shift_q;
        cs_n_n      = cs_n_q;
        sclk_n      = sclk_q;
        din_n       = din_q;
        done_n      = 1'b0;
        busy_n      = busy_q;
        hold_full_n = hold_full_q;
        hold_n      = hold_q;
`ifdef DAC_REPEAT_EN
        last_n      = last_q;
        ur_n        = 1'b0;
`endif

        if (load) begin
            hold_full_n = 1'b1;
            hold_n      = in_data;
        end

        unique case (state_q)
            IDLE: begin
                if (tick && start_ok) begin
                    state_n = SETUP;
                    cnt_n   = '0;
                    bcnt_n  = '0;
                    low_n   = 1'b0;
                    shift_n = word;
                    cs_n_n  = 1'b0;
                    sclk_n  = 1'b0;
                    din_n   = word[FRAME_W-1];
                    busy_n  = 1'b1;
                    if (hold_full_q) begin
                        hold_full_n = 1'b0;
                    end
`ifdef DAC_REPEAT_EN
                    last_n = src;
                    ur_n   = ~hold_full_q;
`endif
                end
            end
            SETUP: begin
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_n   = '0;
                    sclk_n  = 1'b1;
                    low_n   = 1'b0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_n = '0;
                    if (!low_q) begin
                        sclk_n = 1'b0;
                        low_n  = 1'b1;
                        if (bcnt_q != BIT_LAST) begin
                            shift_n = shift_q << 1;
                            din_n   = shift_q[FRAME_W-2];
                        end
                    end else if (bcnt_q == BIT_LAST) begin
                        state_n = IDLE;
                        cs_n_n  = 1'b1;
                        din_n   = 1'b0;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        low_n   = 1'b0;
                    end else begin
                        sclk_n = 1'b1;
                        low_n  = 1'b0;
                        bcnt_n = bcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops CS_N at once mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bcnt_q      <= '0;
            low_q       <= 1'b0;
            shift_q     <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            din_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
`ifdef DAC_REPEAT_EN
            last_q      <= '0;
            ur_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            bcnt_q      <= bcnt_n;
            low_q       <= low_n;
            shift_q     <= shift_n;
            cs_n_q      <= cs_n_n;
            sclk_q      <= sclk_n;
            din_q       <= din_n;
            done_q      <= done_n;
            busy_q      <= busy_n;
            hold_full_q <= hold_full_n;
            hold_q      <= hold_n;
`ifdef DAC_REPEAT_EN
            last_q      <= last_n;
            ur_q        <= ur_n;
`endif
        end
    end

    assign in_ready   = ~hold_full_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
`ifdef DAC_REPEAT_EN
    assign underrun   = ur_q;
`endif

endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: a DAC pin model captures frames, tasks check them.
// Build with +define+DAC_REPEAT_EN to exercise the repeat-on-underrun variant.
module tb_dac_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       dac_cs_n;
    logic       dac_sclk;
    logic       dac_din;
    logic       busy;
    logic       frame_done;
`ifdef DAC_REPEAT_EN
    logic       underrun;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    dac_serial_tx dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dac_cs_n  (dac_cs_n),
        .dac_sclk  (dac_sclk),
        .dac_din   (dac_din),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef DAC_REPEAT_EN
        ,
        .underrun  (underrun)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // DAC pin model: what an external serial DAC would see.
    int          start_q[$];
    bit          rdy_q[$];
    logic [15:0] cap_q[$];
    int          len_q[$];
    int          nb_q[$];
    bit          dq[$];
    int          done_cnt = 0;
    int          ur_cnt = 0;
    int          csl_total = 0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    logic [15:0] sh = 16'h0;
    int          nb = 0;
    int          cl = 0;
    bit          in_frame = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            cs_prev   = 1'b1;
            sclk_prev = 1'b0;
            in_frame  = 1'b0;
        end else begin
            if (cs_prev && !dac_cs_n) begin
                start_q.push_back(cyc);
                rdy_q.push_back(in_ready);
                sh = 16'h0;
                nb = 0;
                cl = 0;
                in_frame = 1'b1;
            end
            if (!dac_cs_n) begin
                cl++;
                csl_total++;
                if (!sclk_prev && dac_sclk) begin
                    sh = {sh[14:0], dac_din};
                    nb++;
                end
            end
            if (!cs_prev && dac_cs_n && in_frame) begin
                cap_q.push_back(sh);
                len_q.push_back(cl);
                nb_q.push_back(nb);
                dq.push_back(frame_done);
                in_frame = 1'b0;
            end
            if (frame_done) done_cnt++;
`ifdef DAC_REPEAT_EN
            if (underrun) ur_cnt++;
`endif
            cs_prev   = dac_cs_n;
            sclk_prev = dac_sclk;
        end
    end

    // Four zero lead bits, the sample, then four zero tail bits.
    function automatic logic [15:0] exp_word(input logic [7:0] d);
        return 16'(d) * 16'd16;
    endfunction

    task automatic do_reset(output int c);
        rst = 1'b1;
        in_valid = 1'b0;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        c = cyc;
    endtask

    task automatic push(input logic [7:0] d, output bit ok);
        in_data = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_caps(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (cap_q.size() >= n) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_starts(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (start_q.size() >= n) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (dac_cs_n !== 1'b1) begin
            fails++;
            $display("FAIL rst_cs_n got %b want 1", dac_cs_n);
        end
        tests++;
        if (dac_sclk !== 1'b0) begin
            fails++;
            $display("FAIL rst_sclk got %b want 0", dac_sclk);
        end
        tests++;
        if (dac_din !== 1'b0) begin
            fails++;
            $display("FAIL rst_din got %b want 0", dac_din);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_busy got %b want 0", busy);
        end
        tests++;
        if (frame_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_done got %b want 0", frame_done);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_ready got %b want 1", in_ready);
        end
`ifdef DAC_REPEAT_EN
        tests++;
        if (underrun !== 1'b0) begin
            fails++;
            $display("FAIL rst_underrun got %b want 0", underrun);
        end
`endif
    endtask

    task automatic test_single(input logic [7:0] d);
        int c, b, s, dn;
        bit ok;
        do_reset(c);
        b = cap_q.size();
        s = start_q.size();
        dn = done_cnt;
        push(d, ok);
        in_valid = 1'b0;
        wait_caps(b + 1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL single_timeout got %0d frames want %0d", cap_q.size(), b + 1);
            return;
        end
        repeat (5) @(negedge clk);
        tests++;
        if (cap_q[b] !== exp_word(d)) begin
            fails++;
            $display("FAIL single_word got %h want %h", cap_q[b], exp_word(d));
        end
        tests++;
        if (len_q[b] != 66) begin
            fails++;
            $display("FAIL single_cs_len got %0d want 66", len_q[b]);
        end
        tests++;
        if (nb_q[b] != 16) begin
            fails++;
            $display("FAIL single_bits got %0d want 16", nb_q[b]);
        end
        tests++;
        if (dq[b] !== 1'b1) begin
            fails++;
            $display("FAIL single_done_at_cs got %b want 1", dq[b]);
        end
        tests++;
        if (done_cnt - dn != 1) begin
            fails++;
            $display("FAIL single_done_count got %0d want 1", done_cnt - dn);
        end
        tests++;
        if (rdy_q[s] !== 1'b1) begin
            fails++;
            $display("FAIL single_ready_after_start got %b want 1", rdy_q[s]);
        end
        tests++;
        if (start_q[s] - c != 80) begin
            fails++;
            $display("FAIL single_first_tick got %0d want 80", start_q[s] - c);
        end
    endtask

    task automatic test_stream(output logic [7:0] last);
        logic [7:0] v[6];
        int c, b, s;
        bit ok;
        v[0] = 8'h00;
        v[1] = 8'hFF;
        v[2] = 8'h80;
        for (int k = 3; k < 6; k++) v[k] = 8'($urandom);
        do_reset(c);
        b = cap_q.size();
        s = start_q.size();
        for (int k = 0; k < 6; k++) begin
            in_data = v[k];
            in_valid = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL stream_load_timeout got %0d want 1", k);
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stream_ready_full got %b want 0", in_ready);
            end
        end
        in_valid = 1'b0;
        last = v[5];
        wait_caps(b + 6, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stream_timeout got %0d frames want %0d", cap_q.size() - b, 6);
            return;
        end
        tests++;
        if (start_q[s] - c != 80) begin
            fails++;
            $display("FAIL stream_first_tick got %0d want 80", start_q[s] - c);
        end
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (cap_q[b + k] !== exp_word(v[k])) begin
                fails++;
                $display("FAIL stream_word[%0d] got %h want %h", k, cap_q[b + k], exp_word(v[k]));
            end
            if (k > 0) begin
                tests++;
                if (start_q[s + k] - start_q[s + k - 1] != 80) begin
                    fails++;
                    $display("FAIL stream_spacing[%0d] got %0d want 80", k, start_q[s + k] - start_q[s + k - 1]);
                end
            end
        end
    endtask

    task automatic test_underrun(input logic [7:0] last);
        int b, s, u, csl;
        bit ok;
        b = cap_q.size();
        s = start_q.size();
        u = ur_cnt;
        csl = csl_total;
`ifdef DAC_REPEAT_EN
        wait_caps(b + 1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL underrun_timeout got %0d frames want 1", cap_q.size() - b);
            return;
        end
        tests++;
        if (cap_q[b] !== exp_word(last)) begin
            fails++;
            $display("FAIL underrun_repeat_word got %h want %h", cap_q[b], exp_word(last));
        end
        tests++;
        if (ur_cnt - u != 1) begin
            fails++;
            $display("FAIL underrun_pulses got %0d want 1", ur_cnt - u);
        end
        tests++;
        if (start_q[s] - start_q[s - 1] != 80) begin
            fails++;
            $display("FAIL underrun_spacing got %0d want 80", start_q[s] - start_q[s - 1]);
        end
`else
        ok = 1'b1;
        repeat (100) @(negedge clk);
        tests++;
        if (start_q.size() - s != 0 || !ok) begin
            fails++;
            $display("FAIL underrun_skip_frames got %0d want 0", start_q.size() - s);
        end
        tests++;
        if (csl_total - csl != 0) begin
            fails++;
            $display("FAIL underrun_cs_low got %0d want 0 (last %h)", csl_total - csl, last);
        end
        tests++;
        if (ur_cnt - u != 0) begin
            fails++;
            $display("FAIL underrun_count got %0d want 0", ur_cnt - u);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] d1, d2;
        int c, b, s;
        bit ok;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        do_reset(c);
        s = start_q.size();
        push(d1, ok);
        in_valid = 1'b0;
        wait_starts(s + 1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rmid_start_timeout got %0d want %0d", start_q.size(), s + 1);
            return;
        end
        b = cap_q.size();
        repeat (29) @(posedge clk);
        #3;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rmid_busy_before got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (dac_cs_n !== 1'b1) begin
            fails++;
            $display("FAIL rmid_cs_n got %b want 1", dac_cs_n);
        end
        tests++;
        if (dac_sclk !== 1'b0) begin
            fails++;
            $display("FAIL rmid_sclk got %b want 0", dac_sclk);
        end
        tests++;
        if (dac_din !== 1'b0) begin
            fails++;
            $display("FAIL rmid_din got %b want 0", dac_din);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rmid_ready got %b want 1", in_ready);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        c = cyc;
        s = start_q.size();
        tests++;
        if (cap_q.size() != b) begin
            fails++;
            $display("FAIL rmid_aborted_frame got %0d want %0d", cap_q.size(), b);
        end
        push(d2, ok);
        in_valid = 1'b0;
        wait_caps(b + 1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rmid_timeout got %0d want %0d", cap_q.size(), b + 1);
            return;
        end
        tests++;
        if (cap_q[b] !== exp_word(d2)) begin
            fails++;
            $display("FAIL rmid_word got %h want %h", cap_q[b], exp_word(d2));
        end
        tests++;
        if (start_q[s] - c != 80) begin
            fails++;
            $display("FAIL rmid_first_tick got %0d want 80", start_q[s] - c);
        end
    endtask

    task automatic test_enable();
        logic [7:0] d1, d2;
        int c, b, s, s2;
        bit ok;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        do_reset(c);
        b = cap_q.size();
        s = start_q.size();
        push(d1, ok);
        in_valid = 1'b0;
        wait_starts(s + 1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL en_start_timeout got %0d want %0d", start_q.size(), s + 1);
            return;
        end
        repeat (10) @(posedge clk);
        #1 en = 1'b0;
        push(d2, ok);
        in_valid = 1'b0;
        wait_caps(b + 1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL en_frame_timeout got %0d want %0d", cap_q.size(), b + 1);
            return;
        end
        tests++;
        if (cap_q[b] !== exp_word(d1)) begin
            fails++;
            $display("FAIL en_word got %h want %h", cap_q[b], exp_word(d1));
        end
        tests++;
        if (nb_q[b] != 16) begin
            fails++;
            $display("FAIL en_bits got %0d want 16", nb_q[b]);
        end
        s2 = start_q.size();
        repeat (200) @(negedge clk);
        tests++;
        if (start_q.size() != s2) begin
            fails++;
            $display("FAIL en_no_frames got %0d want %0d", start_q.size(), s2);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL en_hold_full got %b want 0", in_ready);
        end
        @(posedge clk);
        #1 en = 1'b1;
        c = cyc;
        wait_caps(b + 2, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL en_resume_timeout got %0d want %0d", cap_q.size(), b + 2);
            return;
        end
        tests++;
        if (cap_q[b + 1] !== exp_word(d2)) begin
            fails++;
            $display("FAIL en_resume_word got %h want %h", cap_q[b + 1], exp_word(d2));
        end
        tests++;
        if (start_q[s2] - c != 80) begin
            fails++;
            $display("FAIL en_resume_tick got %0d want 80", start_q[s2] - c);
        end
    endtask

    initial begin
        logic [7:0] last;
        test_reset();
        test_single(8'hA5);
        test_single(8'($urandom));
        test_single(8'($urandom));
        test_stream(last);
        test_underrun(last);
        test_reset_mid();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
